euler_join_unit: RTL and testbench

- N-channel successor to the two-input Euler join stage.
- Each derivative pipe delivers its partial term independently. The block holds each term until every channel has reported.
- It then forms y_step = h_step * (sum of all terms) in signed fixed point, saturating on overflow, and emits the result with an auto-incrementing write address for the result RAM.
- Lifts the old same-cycle-ready requirement; adds sticky error reporting and a loadable base address.

---
 rtl/euler_join_unit_pkg.sv | 27 ++
 rtl/euler_join_unit_mult.sv | 62 ++++++
 rtl/euler_join_unit.sv | 181 ++++++++++++++++++
 tb/tb_euler_join_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/euler_join_unit_pkg.sv
// Shared types and helpers for the N-channel Euler join unit.
// State encoding, saturation bounds and data_pipe slicing.
package euler_join_unit_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_SUM     = 2'd1,
        ST_MUL     = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    // Largest value of a w-bit signed word.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    // Smallest value of a w-bit signed word.
    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // LSB position of channel ch in a packed bus of w-bit terms.
    function automatic int slice_lsb(input int ch, input int w);
        return ch * w;
    endfunction

endpackage

// File: rtl/euler_join_unit_mult.sv
// Sequential signed radix-2 multiplier with sign correction.
// Bit 0 is consumed on the start edge; done pulses WIDTH-1 edges later.
import euler_join_unit_pkg::*;

module seq_mult_signed #(
    parameter int WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   a,
    input  logic signed [WIDTH-1:0]   b,
    output logic                      done,
    output logic signed [2*WIDTH-1:0] product
);

    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic signed [PW-1:0] mcand;
    logic [WIDTH-1:0]     mplier;
    logic [CW-1:0]        cnt;
    logic                 run;

    // Shift-add; the sign bit of b carries weight -2^(WIDTH-1), so subtract.
    always_ff @(posedge clk) begin
        if (rst) begin
            run     <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            product <= '0;
            mcand   <= '0;
            mplier  <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                product <= b[0] ? PW'(a) : '0;
                mcand   <= PW'(a) <<< 1;
                mplier  <= {1'b0, b[WIDTH-1:1]};
                cnt     <= CW'(1);
                run     <= 1'b1;
            end else if (run) begin
                if (cnt == LAST) begin
                    if (mplier[0]) begin
                        product <= product - mcand;
                    end
                    done <= 1'b1;
                    run  <= 1'b0;
                end else begin
                    if (mplier[0]) begin
                        product <= product + mcand;
                    end
                    mcand  <= mcand <<< 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/euler_join_unit.sv
// N-channel Euler join: collect one term per channel, then emit
// saturated h_step * sum with an auto-incrementing write address.
import euler_join_unit_pkg::*;

module euler_join_unit #(
    parameter int ADD_SIZE  = 16,
    parameter int DATA_SIZE = 16,
    parameter int FRAC_BITS = 8,
    parameter int N_CH      = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clear,
    input  logic [N_CH-1:0]             data_ready,
    input  logic [N_CH*DATA_SIZE-1:0]   data_pipe,
    input  logic [DATA_SIZE-1:0]        h_step,
    input  logic                        addr_load,
    input  logic [ADD_SIZE-1:0]         base_addr,
    output logic                        busy,
    output logic                        result_valid,
    output logic [DATA_SIZE-1:0]        result,
    output logic [ADD_SIZE-1:0]         wr_addr,
    output logic                        overflow_flag,
    output logic                        collision_flag,
    output logic                        return_default_state
);

    localparam int DW = DATA_SIZE;
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(N_CH - 1);
    localparam logic signed [DW-1:0] SMAX = DW'(sat_max(DW));
    localparam logic signed [DW-1:0] SMIN = DW'(sat_min(DW));

    logic [DW-1:0]         chan [N_CH];
    logic [DW-1:0]         slot [N_CH];
    logic [N_CH-1:0]       full;
    logic                  all_full;
    state_t                state;
    logic [IW-1:0]         idx;
    logic signed [DW-1:0]  acc;
    logic [ADD_SIZE-1:0]   addr_cnt;

    logic [DW:0]           sum_wide;
    logic                  sum_ovf;
    logic signed [DW-1:0]  sum_sat;
    logic [DW-1:0]         slot_sel;

    logic                  mul_start;
    logic                  mul_done;
    logic signed [2*DW-1:0] prod;
    logic signed [2*DW-1:0] shifted;
    logic [DW:0]           hi_bits;
    logic                  scale_ovf;
    logic signed [DW-1:0]  scaled;

    for (genvar g = 0; g < N_CH; g++) begin : g_chan
        assign chan[g] = data_pipe[slice_lsb(g, DW) +: DW];
    end

    // Strobes arriving this cycle also count toward completion.
    assign all_full = &(full | data_ready);

    assign slot_sel = slot[idx];
    assign sum_wide = {acc[DW-1], acc} + {slot_sel[DW-1], slot_sel};
    assign sum_ovf  = sum_wide[DW] ^ sum_wide[DW-1];
    assign sum_sat  = sum_ovf ? (sum_wide[DW] ? SMIN : SMAX)
                              : sum_wide[DW-1:0];

    // The final sum feeds the multiplier on the last SUM edge.
    assign mul_start = (state == ST_SUM) && (idx == LAST_IDX);

    seq_mult_signed #(
        .WIDTH(DW)
    ) u_mult (
        .clk    (clk),
        .rst    (rst || clear),
        .start  (mul_start),
        .a      (sum_sat),
        .b      (h_step),
        .done   (mul_done),
        .product(prod)
    );

    // Floor scaling, then clamp when the upper bits are not a sign run.
    assign shifted   = prod >>> FRAC_BITS;
    assign hi_bits   = shifted[2*DW-1:DW-1];
    assign scale_ovf = !((&hi_bits) || !(|hi_bits));
    assign scaled    = scale_ovf ? (shifted[2*DW-1] ? SMIN : SMAX)
                                 : shifted[DW-1:0];

    // Slot capture: first strobe into an empty slot wins, DONE empties all.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= '0;
        end else if (state == ST_DONE) begin
            full <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (data_ready[i] && !full[i]) begin
                    full[i] <= 1'b1;
                    slot[i] <= chan[i];
                end
            end
        end
    end

    // Sticky collision detection on strobes into occupied slots.
    always_ff @(posedge clk) begin
        if (rst) begin
            collision_flag <= 1'b0;
        end else if (!clear && |(data_ready & full)) begin
            collision_flag <= 1'b1;
        end
    end

    // Sequencer with registered outputs and the write-address counter.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state                <= ST_COLLECT;
            busy                 <= 1'b0;
            result_valid         <= 1'b0;
            return_default_state <= 1'b0;
            idx                  <= '0;
            acc                  <= '0;
            if (rst) begin
                result        <= '0;
                wr_addr       <= '0;
                overflow_flag <= 1'b0;
                addr_cnt      <= '0;
            end else if (addr_load) begin
                addr_cnt <= base_addr;
            end
        end else begin
            result_valid         <= 1'b0;
            return_default_state <= 1'b0;
            if (addr_load) begin
                addr_cnt <= base_addr;
            end else if (state == ST_DONE) begin
                addr_cnt <= addr_cnt + 1'b1;
            end
            unique case (state)
                ST_COLLECT: begin
                    if (all_full) begin
                        state                <= ST_SUM;
                        busy                 <= 1'b1;
                        return_default_state <= 1'b1;
                        idx                  <= '0;
                        acc                  <= '0;
                    end
                end
                ST_SUM: begin
                    acc <= sum_sat;
                    if (sum_ovf) begin
                        overflow_flag <= 1'b1;
                    end
                    if (idx == LAST_IDX) begin
                        state <= ST_MUL;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_MUL: begin
                    if (mul_done) begin
                        state        <= ST_DONE;
                        result       <= scaled;
                        result_valid <= 1'b1;
                        wr_addr      <= addr_cnt;
                        if (scale_ovf) begin
                            overflow_flag <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_COLLECT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_euler_join_unit.sv
// Scoreboard bench for euler_join_unit: stimulus pushes expected
// results, a negedge monitor pops and compares on result_valid.
module tb_euler_join_unit;

    localparam int AW = 16;
    localparam int DW = 16;
    localparam int FB = 8;
    localparam int NC = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic [NC-1:0]    data_ready;
    logic [NC*DW-1:0] data_pipe;
    logic [DW-1:0]    h_step;
    logic             addr_load;
    logic [AW-1:0]    base_addr;
    logic             busy;
    logic             result_valid;
    logic [DW-1:0]    result;
    logic [AW-1:0]    wr_addr;
    logic             overflow_flag;
    logic             collision_flag;
    logic             return_default_state;

    euler_join_unit #(
        .ADD_SIZE (AW),
        .DATA_SIZE(DW),
        .FRAC_BITS(FB),
        .N_CH     (NC)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clear               (clear),
        .data_ready          (data_ready),
        .data_pipe           (data_pipe),
        .h_step              (h_step),
        .addr_load           (addr_load),
        .base_addr           (base_addr),
        .busy                (busy),
        .result_valid        (result_valid),
        .result              (result),
        .wr_addr             (wr_addr),
        .overflow_flag       (overflow_flag),
        .collision_flag      (collision_flag),
        .return_default_state(return_default_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] res;
        logic [AW-1:0] addr;
        int            cyc;
    } exp_t;

    exp_t          sb[$];
    int            checks   = 0;
    int            failures = 0;
    int            cyc      = 0;
    logic [AW-1:0] exp_addr = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid !== 1'b0) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got %0h expected none",
                         result);
            end else begin : pop
                exp_t e;
                e = sb.pop_front();
                check("result", result, e.res);
                check("wr_addr", wr_addr, e.addr);
                check("latency", cyc, e.cyc);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [NC-1:0] m, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, output int e);
        data_ready = m;
        data_pipe  = {d1, d0};
        tick(1);
        e          = cyc;
        data_ready = '0;
    endtask

    task automatic push(input int e, input logic [DW-1:0] r);
        sb.push_back('{r, exp_addr, e + NC + DW});
        exp_addr = exp_addr + 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0",
                     sb.size());
            sb.delete();
        end
        tick(1);
    endtask

    task automatic op(input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                      input logic [DW-1:0] h, input logic [DW-1:0] r);
        int e;
        h_step = h;
        strobe(2'b11, d0, d1, e);
        push(e, r);
        drain();
    endtask

    task automatic load_base(input logic [AW-1:0] b);
        addr_load = 1'b1;
        base_addr = b;
        tick(1);
        addr_load = 1'b0;
        exp_addr  = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst      = 1'b0;
        exp_addr = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        rst        = 1'b1;
        clear      = 1'b0;
        data_ready = '0;
        data_pipe  = '0;
        h_step     = '0;
        addr_load  = 1'b0;
        base_addr  = '0;
        tick(2);
        rst = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_valid", result_valid, 0);
        check("rst_result", result, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_overflow", overflow_flag, 0);
        check("rst_collision", collision_flag, 0);
        check("rst_rds", return_default_state, 0);

        // Staggered arrival, half step.
        load_base(16'h0010);
        h_step = 16'h0080;
        strobe(2'b01, 16'h0200, 16'h0000, e);
        tick(2);
        strobe(2'b10, 16'h0000, 16'h0100, e);
        push(e, 16'h0180);
        drain();
        check("t1_overflow", overflow_flag, 0);
        check("t1_collision", collision_flag, 0);
        check("t1_hold", result, 16'h0180);
        check("t1_valid_low", result_valid, 0);

        // Negative terms in the same cycle.
        h_step = 16'h0100;
        strobe(2'b11, 16'hFF00, 16'hFE00, e);
        push(e, 16'hFD00);
        check("t2_rds_high", return_default_state, 1);
        check("t2_busy", busy, 1);
        tick(1);
        check("t2_rds_low", return_default_state, 0);
        drain();
        check("t2_busy_idle", busy, 0);

        // Saturating sum, then a clean op keeps the sticky flag.
        op(16'h7F00, 16'h7F00, 16'h0200, 16'h7FFF);
        check("t3_overflow", overflow_flag, 1);
        op(16'h0200, 16'h0100, 16'h0080, 16'h0180);
        check("t3_overflow_sticky", overflow_flag, 1);

        do_reset();
        check("t3_rst_overflow", overflow_flag, 0);
        check("t3_rst_wr_addr", wr_addr, 0);

        // Double strobe on ch0: first value wins.
        h_step = 16'h0100;
        strobe(2'b01, 16'h0100, 16'h0000, e);
        check("t4_no_collision", collision_flag, 0);
        strobe(2'b01, 16'h0500, 16'h0000, e);
        check("t4_collision", collision_flag, 1);
        strobe(2'b10, 16'h0000, 16'h0100, e);
        push(e, 16'h0200);
        drain();

        do_reset();
        check("t4_rst_collision", collision_flag, 0);

        // Strobe while multiplying is dropped and flagged.
        strobe(2'b11, 16'h0300, 16'h0100, e);
        push(e, 16'h0400);
        tick(5);
        strobe(2'b10, 16'h0000, 16'h7777, e);
        check("t4_mul_collision", collision_flag, 1);
        drain();

        // Address wrap.
        load_base(16'hFFFE);
        op(16'h0100, 16'h0100, 16'h0100, 16'h0200);
        op(16'h0100, 16'h0100, 16'h0100, 16'h0200);
        op(16'h0100, 16'h0100, 16'h0100, 16'h0200);

        // Clear during the fifth MUL cycle.
        h_step = 16'h0100;
        strobe(2'b11, 16'h0100, 16'h0200, e);
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t6_busy", busy, 0);
        check("t6_valid", result_valid, 0);
        check("t6_overflow", overflow_flag, 0);
        check("t6_collision", collision_flag, 1);
        tick(25);
        op(16'h0100, 16'h0200, 16'h0100, 16'h0300);

        check("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
